// File: rtl/vispart_tx.sv
// vispart_tx: serialises NSUMS-lane partial-sum blocks into a framed word stream
module vispart_tx #(
  parameter int IBITS = 5,
  parameter int OBITS = 8,
  parameter int ABITS = 2,
  parameter int NSUMS = 1 << ABITS
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [NSUMS*IBITS-1:0] data_i,
  output logic                   valid_o,
  output logic                   first_o,
  output logic                   last_o,
  output logic [IBITS-1:0]       data_o,
  output logic                   busy_o
);
  localparam int SBITS = OBITS - IBITS;
  typedef enum logic {IDLE, SEND} state_t;
  state_t                 state;
  logic [NSUMS*IBITS-1:0] buffer;
  logic [ABITS-1:0]       sel;
  logic [SBITS-1:0]       blk;
  logic                   last_lane;
  assign last_lane = sel == ABITS'(NSUMS - 1);
  assign ready_o   = state == IDLE || last_lane;
  assign busy_o    = state == SEND;
  // Emit one buffered lane per cycle; a block accepted on the final lane keeps the stream gapless
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      buffer  <= '0;
      sel     <= '0;
      blk     <= '0;
      valid_o <= 1'b0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      if (state == SEND) begin
        valid_o <= 1'b1;
        data_o  <= buffer[sel*IBITS +: IBITS];
        first_o <= blk == '0;
        last_o  <= &blk;
        sel     <= sel + 1'b1;
        if (last_lane) blk <= blk + 1'b1;
        if (last_lane && !valid_i) state <= IDLE;
      end else begin
        valid_o <= 1'b0;
        first_o <= 1'b0;
        last_o  <= 1'b0;
      end
      if (valid_i && ready_o) begin
        buffer <= data_i;
        sel    <= '0;
        state  <= SEND;
      end
    end
endmodule
